// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus constants and types for the yutorina bus arbiter.
package yutorina_bus_arbiter_pkg;

    localparam int unsigned BusMasterCh = 4;

    typedef logic [1:0] bus_owner_t;

    typedef enum logic {
        BusArbIdle = 1'b0,
        BusArbBusy = 1'b1
    } bus_arb_state_e;

    // Active-low control levels used on req/grant/as/rdy lines.
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    // Owner value after reset so the first pick starts at master 0.
    localparam bus_owner_t OwnerReset = 2'd3;

    // Active-low one-hot grant vector for a single owner.
    function automatic logic [BusMasterCh-1:0] grant_vec(input bus_owner_t idx);
        logic [BusMasterCh-1:0] g;
        g      = '1;
        g[idx] = Enable_;
        return g;
    endfunction

endpackage

// File: rtl/yutorina_bus_rr_pick.sv
// Combinational round-robin picker: scans start+1, start+2, start+3, start (mod 4)
// for the first active-low request, optionally skipping one index.
module yutorina_bus_rr_pick
    import yutorina_bus_arbiter_pkg::*;
(
    input  logic [BusMasterCh-1:0] req_,
    input  bus_owner_t             start,
    input  logic                   excl_en,
    input  bus_owner_t             excl_idx,
    output logic                   valid,
    output bus_owner_t             idx
);

    // First eligible requester in rotation order after start.
    always_comb begin
        bus_owner_t cand;
        valid = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 1; i <= BusMasterCh; i++) begin
            cand = start + 2'(i);
            if (!valid && (req_[cand] == Enable_) && !(excl_en && (cand == excl_idx))) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with registered active-low grants and an
// optional tenure limit that forces handover only at a transfer boundary.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    input  logic       m_as_,
    input  logic       m_rdy_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       busy
);

    localparam logic [HOLD_W-1:0] MaxHoldCnt = HOLD_W'(MAX_HOLD);

    bus_arb_state_e         state_q, state_d;
    bus_owner_t             owner_q, owner_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [BusMasterCh-1:0] grnt_q, grnt_d;
    logic                   busy_q, busy_d;

    logic [BusMasterCh-1:0] req_vec;
    logic                   pick_valid;
    bus_owner_t             pick_idx;
    logic                   boundary;
    logic                   owner_req;
    logic                   force_handover;

    assign req_vec   = {m3_req_, m2_req_, m1_req_, m0_req_};
    assign boundary  = (m_as_ == Disable_) || (m_rdy_ == Enable_);
    assign owner_req = (req_vec[owner_q] == Enable_);

    // While busy the current owner is never a handover candidate.
    yutorina_bus_rr_pick u_pick (
        .req_     (req_vec),
        .start    (owner_q),
        .excl_en  (state_q == BusArbBusy),
        .excl_idx (owner_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    assign force_handover = (MAX_HOLD != 0) && (hold_cnt_q == MaxHoldCnt) &&
                            pick_valid && boundary;

    // Next-state: idle pick, release handover, forced handover, tenure count.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        grnt_d     = grnt_q;
        busy_d     = busy_q;
        unique case (state_q)
            BusArbIdle: begin
                if (pick_valid) begin
                    state_d    = BusArbBusy;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                    grnt_d     = grant_vec(pick_idx);
                    busy_d     = 1'b1;
                end
            end
            BusArbBusy: begin
                if (!owner_req) begin
                    if (pick_valid) begin
                        owner_d    = pick_idx;
                        hold_cnt_d = '0;
                        grnt_d     = grant_vec(pick_idx);
                    end else begin
                        state_d    = BusArbIdle;
                        hold_cnt_d = '0;
                        grnt_d     = '1;
                        busy_d     = 1'b0;
                    end
                end else if (force_handover) begin
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                    grnt_d     = grant_vec(pick_idx);
                end else if (hold_cnt_q != MaxHoldCnt) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BusArbIdle;
                grnt_d  = '1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset dominating everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BusArbIdle;
            owner_q    <= OwnerReset;
            hold_cnt_q <= '0;
            grnt_q     <= '1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            grnt_q     <= grnt_d;
            busy_q     <= busy_d;
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench for yutorina_bus_arbiter with MAX_HOLD = 4.
module tb_yutorina_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       m_as_;
    logic       m_rdy_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] gnt;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    assign gnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    yutorina_bus_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (req[0]),
        .m1_req_  (req[1]),
        .m2_req_  (req[2]),
        .m3_req_  (req[3]),
        .m_as_    (m_as_),
        .m_rdy_   (m_rdy_),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gexp(input int idx);
        logic [3:0] g;
        g = 4'b1111;
        g[idx] = 1'b0;
        return g;
    endfunction

    initial begin
        reset  = 1'b1;
        req    = 4'b1011;
        m_as_  = 1'b1;
        m_rdy_ = 1'b1;

        // Reset with m2 requesting: no grant while reset is held.
        step();
        chk("rst_gnt0", 32'(gnt), 32'hF);
        chk("rst_owner", 32'(owner), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        chk("rst_gnt1", 32'(gnt), 32'hF);
        reset = 1'b0;
        step();
        chk("first_gnt", 32'(gnt), 32'(4'b1011));
        chk("first_owner", 32'(owner), 32'd2);
        chk("first_busy", 32'(busy), 32'd1);
        req = 4'b1111;
        step();
        chk("rel_idle_gnt", 32'(gnt), 32'hF);
        chk("rel_idle_busy", 32'(busy), 32'd0);
        chk("rel_idle_owner", 32'(owner), 32'd2);

        // Round robin from reset with all four requesting: order 0,1,2,3,0.
        req   = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("rr_owner", 32'(owner), 32'(k % 4));
            chk("rr_gnt", 32'(gnt), 32'(gexp(k % 4)));
            chk("rr_busy", 32'(busy), 32'd1);
            step();
            chk("rr_hold1", 32'(gnt), 32'(gexp(k % 4)));
            step();
            chk("rr_hold2", 32'(gnt), 32'(gexp(k % 4)));
            if (k < 4) begin
                req[k % 4] = 1'b1;
                step();
                req[k % 4] = 1'b0;
            end
        end
        req = 4'b1111;
        step();
        chk("rr_end_gnt", 32'(gnt), 32'hF);
        chk("rr_end_owner", 32'(owner), 32'd0);

        // Release handover m1 -> m3 in one edge.
        req = 4'b1101;
        step();
        chk("ho_m1_gnt", 32'(gnt), 32'(4'b1101));
        req = 4'b0101;
        step();
        chk("ho_m1_keep", 32'(gnt), 32'(4'b1101));
        req = 4'b0111;
        step();
        chk("ho_m3_gnt", 32'(gnt), 32'(4'b0111));
        chk("ho_m3_owner", 32'(owner), 32'd3);
        chk("ho_m3_busy", 32'(busy), 32'd1);
        req = 4'b1111;
        step();
        chk("ho_idle", 32'(gnt), 32'hF);

        // Forced handover at boundary (m_as_ high).
        req = 4'b1110;
        step();
        chk("fh_m0_gnt", 32'(gnt), 32'(4'b1110));
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fh_m0_hold", 32'(gnt), 32'(4'b1110));
        end
        chk("fh_cnt", 32'(dut.hold_cnt_q), 32'd4);
        step();
        chk("fh_m2_gnt", 32'(gnt), 32'(4'b1011));
        chk("fh_m2_owner", 32'(owner), 32'd2);

        // Forced handover delayed by wait states.
        req = 4'b1110;
        step();
        chk("ws_m0_gnt", 32'(gnt), 32'(4'b1110));
        req    = 4'b1010;
        m_as_  = 1'b0;
        m_rdy_ = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("ws_m0_hold", 32'(gnt), 32'(4'b1110));
        end
        m_rdy_ = 1'b0;
        step();
        chk("ws_m2_gnt", 32'(gnt), 32'(4'b1011));
        chk("ws_m2_owner", 32'(owner), 32'd2);
        m_as_  = 1'b1;
        m_rdy_ = 1'b1;

        // Sole requester keeps the bus past the limit; counter saturates.
        req = 4'b1110;
        step();
        chk("sat_m0_gnt", 32'(gnt), 32'(4'b1110));
        for (int i = 0; i < 20; i++) begin
            step();
            chk("sat_hold", 32'(gnt), 32'(4'b1110));
        end
        chk("sat_cnt", 32'(dut.hold_cnt_q), 32'd4);

        // Reset mid-transfer while m1 owns the bus.
        req = 4'b1101;
        step();
        chk("mr_m1_gnt", 32'(gnt), 32'(4'b1101));
        m_as_ = 1'b0;
        req   = 4'b1001;
        reset = 1'b1;
        step();
        chk("mr_gnt", 32'(gnt), 32'hF);
        chk("mr_owner", 32'(owner), 32'd3);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cnt", 32'(dut.hold_cnt_q), 32'd0);
        reset = 1'b0;
        m_as_ = 1'b1;
        step();
        chk("mr_m1_first", 32'(gnt), 32'(4'b1101));
        chk("mr_m1_owner", 32'(owner), 32'd1);
        chk("mr_m1_busy", 32'(busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
